dynamic_priority_encoder: RTL and testbench
===========================================

Name: dynamic_priority_encoder

Overview:
Rotating-priority encoder for an N-bit request vector. The caller supplies the index of the highest-priority bit. The block returns the index of the first set request found, searching upward from that index with wrap-around, plus a valid flag. Outputs are registered, and the block sits in front of round-robin style arbiters and grant logic.

Parameters:
N, 8, number of request lines; power of two, at least 2
IDX_W, 3, index width, equal to log2(N); default matches N=8

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
in  input  N  request vector; bit i set means line i requests
priority  input  IDX_W  index of the highest-priority request line for this evaluation
grant  output  IDX_W  registered index of the winning request line
valid  output  1  registered; 1 when any bit of in was set

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset: while rst=1, grant=0 and valid=0, regardless of clk.
- Search order: in[priority], in[priority+1], ..., in[N-1], in[0], ..., in[priority-1]. Index arithmetic is mod N.
- Winner: the first set bit in that order.
- Combinational result: win_idx = winner index; any = |in. When in=0, win_idx=0.
- Registered outputs: on each rising clk edge with rst=0, grant<=win_idx and valid<=any.
- Latency: exactly 1 cycle from sampled in/priority to grant/valid. A new result every cycle; no handshake, no stall.
- Empty input: valid=0 and grant=0; grant must not hold its previous value.
- Full input (all ones): grant=priority, valid=1.
- priority=0: plain LSB-first encoder, lowest set bit wins.
- Wrap-around: if no set bit is found at index >= priority, the lowest set bit below priority wins.
- Single set bit: grant is that bit's index for every priority value.
- Reset mid-operation: outputs clear immediately (asynchronous). The first result after rst deasserts appears on the first rising edge with rst=0.
- priority covers 0..N-1 fully; there is no illegal value.
- Implementation: any equivalent structure (doubled vector plus fixed encoder, or a rotate–encode–add pair) is acceptable. Must be synthesizable, with no latches in the combinational path.

Test Plan:
- Reset: assert rst with in=8'hFF, priority=3 -> grant=0, valid=0 immediately; after release and one edge -> grant=3, valid=1.
- Empty and basic: in=8'b00000000, priority=0 -> grant=0, valid=0. Then in=8'b00100000, priority=0 -> grant=5, valid=1.
- Wrap: in=8'b00010000, priority=6 -> grant=4. Then in=8'b00000001, priority=3 -> grant=0, valid=1.
- Priority hit: in=8'b11000000, priority=7 -> grant=7. Then same in with priority=0 -> grant=6.
- Full sweep: in=8'hFF, priority 0..7 -> grant equals priority. in=8'b10000001, priority=1 -> grant=7.
- Random: 1000 random in/priority vectors compared against a reference model with a one-cycle delay; include rst pulses asserted between clock edges.

Source files
------------

// File: rtl/dynamic_priority_encoder.sv
// dynamic_priority_encoder: rotating-priority encoder with registered grant index and valid flag
module dynamic_priority_encoder #(
  parameter int N = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic [IDX_W-1:0] prio,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);
  logic [N-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] win_idx;
  logic any;
  assign rot = N'({in, in} >> prio);
  assign any = |in;
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? IDX_W'(k) : off;
  end
  assign win_idx = any ? prio + off : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      valid <= 1'b0;
    end else begin
      grant <= win_idx;
      valid <= any;
    end
  end
endmodule

// File: tb/tb_dynamic_priority_encoder.sv
// tb_dynamic_priority_encoder: directed and randomized checks of the rotating-priority encoder
module tb_dynamic_priority_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] in = '0;
  logic [2:0] prio = '0;
  logic [2:0] grant;
  logic valid;
  int checks = 0;
  int failures = 0;
  dynamic_priority_encoder #(.N(8), .IDX_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .prio(prio),
    .grant(grant),
    .valid(valid)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] ref_enc(input logic [7:0] v, input logic [2:0] p);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (int'(p) + k) % 8;
      if (v[j]) return 3'(j);
    end
    return 3'd0;
  endfunction
  task automatic step(input logic [7:0] v, input logic [2:0] p);
    @(negedge clk);
    in = v;
    prio = p;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    step(8'hFF, 3'd3);
    step(8'hFF, 3'd3);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 3'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got grant=%0d valid=%b want grant=0 valid=0", grant, valid);
    end
    @(negedge clk);
    checks++;
    if (grant !== 3'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got grant=%0d valid=%b want grant=0 valid=0", grant, valid);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 3'd3 || valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got grant=%0d valid=%b want grant=3 valid=1", grant, valid);
    end
  endtask
  task automatic test_empty_basic;
    step(8'b00000000, 3'd0);
    checks++;
    if (grant !== 3'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL empty: got grant=%0d valid=%b want grant=0 valid=0", grant, valid);
    end
    step(8'b00100000, 3'd0);
    checks++;
    if (grant !== 3'd5 || valid !== 1'b1) begin
      failures++;
      $display("FAIL basic: got grant=%0d valid=%b want grant=5 valid=1", grant, valid);
    end
    step(8'b00000000, 3'd5);
    checks++;
    if (grant !== 3'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_no_hold: got grant=%0d valid=%b want grant=0 valid=0", grant, valid);
    end
  endtask
  task automatic test_wrap;
    step(8'b00010000, 3'd6);
    checks++;
    if (grant !== 3'd4 || valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_a: got grant=%0d valid=%b want grant=4 valid=1", grant, valid);
    end
    step(8'b00000001, 3'd3);
    checks++;
    if (grant !== 3'd0 || valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_b: got grant=%0d valid=%b want grant=0 valid=1", grant, valid);
    end
    step(8'b10000001, 3'd1);
    checks++;
    if (grant !== 3'd7 || valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_c: got grant=%0d valid=%b want grant=7 valid=1", grant, valid);
    end
  endtask
  task automatic test_priority_hit;
    step(8'b11000000, 3'd7);
    checks++;
    if (grant !== 3'd7 || valid !== 1'b1) begin
      failures++;
      $display("FAIL prio_hit: got grant=%0d valid=%b want grant=7 valid=1", grant, valid);
    end
    step(8'b11000000, 3'd0);
    checks++;
    if (grant !== 3'd6 || valid !== 1'b1) begin
      failures++;
      $display("FAIL prio_zero: got grant=%0d valid=%b want grant=6 valid=1", grant, valid);
    end
  endtask
  task automatic test_sweep;
    for (int p = 0; p < 8; p++) begin
      step(8'hFF, 3'(p));
      checks++;
      if (grant !== 3'(p) || valid !== 1'b1) begin
        failures++;
        $display("FAIL full_sweep p=%0d: got grant=%0d valid=%b want grant=%0d valid=1", p, grant, valid, p);
      end
    end
    for (int p = 0; p < 8; p++) begin
      step(8'b00000100, 3'(p));
      checks++;
      if (grant !== 3'd2 || valid !== 1'b1) begin
        failures++;
        $display("FAIL single_bit p=%0d: got grant=%0d valid=%b want grant=2 valid=1", p, grant, valid);
      end
    end
  endtask
  task automatic test_random;
    logic [7:0] v;
    logic [2:0] p;
    for (int i = 0; i < 1000; i++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 7) == 0) v = 8'h00;
      p = 3'($urandom);
      step(v, p);
      checks++;
      if (grant !== ref_enc(v, p) || valid !== (|v)) begin
        failures++;
        $display("FAIL random i=%0d in=%b prio=%0d: got grant=%0d valid=%b want grant=%0d valid=%b", i, v, p, grant, valid, ref_enc(v, p), |v);
      end
      if (i % 97 == 50) begin
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 3'd0 || valid !== 1'b0) begin
          failures++;
          $display("FAIL random_rst i=%0d: got grant=%0d valid=%b want grant=0 valid=0", i, grant, valid);
        end
        rst = 1'b0;
      end
    end
  endtask
  initial begin
    test_reset;
    test_empty_basic;
    test_wrap;
    test_priority_hit;
    test_sweep;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
